// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding, default vectors and the instruction size.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Redirect arbitration: exception beats jump beats branch, and the winning
// target is word aligned. With no redirect, target simply passes pc through.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        exc_valid,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] pc,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = exc_valid | jmp_valid | br_taken;
        if (exc_valid) begin
            target = word_align(EXC_VECTOR);
        end else if (jmp_valid) begin
            target = word_align(jmp_target);
        end else if (br_taken) begin
            target = word_align(br_target);
        end else begin
            target = pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding-request instruction fetch controller. Fetches one word,
// holds it for the consumer, and handles redirects arriving at any time.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;
    logic        kill_q, kill_d;

    logic        redirect;
    logic [31:0] target;

    fetch_next_pc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .exc_valid  (exc_valid),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc_q),
        .redirect   (redirect),
        .target     (target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VECTOR;
            addr_q    <= RESET_VECTOR;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            valid_q   <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            kill_q    <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ack && !kill_q && !redirect) state_d = DELIVER;
            DELIVER: if (redirect || !stall) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // target equals pc_q when no redirect is active, so it doubles as the
    // "redirect target or current pc" refetch address.
    always_comb begin
        pc_d      = target;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        kill_d    = kill_q;
        case (state_q)
            IDLE: begin
                addr_d = target;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (kill_q || redirect) begin
                        kill_d = 1'b0;
                        addr_d = target;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = addr_q;
                        valid_d   = 1'b1;
                        pc_d      = addr_q + INSTR_BYTES;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            DELIVER: begin
                if (redirect || !stall) begin
                    valid_d = 1'b0;
                    addr_d  = target;
                end
            end
            default: begin
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        imem_req   = (state_q == FETCH);
        imem_addr  = addr_q;
        inst_valid = valid_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        pc         = pc_q;
    end

endmodule
